// File: rtl/vga_pkg.sv
// Shared raster timing constants and the pixel coordinate type
// for the VGA timing generator and its pipeline helpers.
package vga_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_H_VISIBLE  = 640;
    localparam int DEF_H_FRONT    = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BACK     = 48;
    localparam int DEF_V_VISIBLE  = 480;
    localparam int DEF_V_FRONT    = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BACK     = 33;
    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_PIPE_DELAY = 2;

    localparam int DEF_H_TOTAL =
        DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL =
        DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    function automatic logic in_window(
        input coord_t v,
        input coord_t lo,
        input coord_t hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Resettable-to-one shift register that lines sync up with the
// colour pipeline; depth zero is a straight wire.
module vga_sync_delay #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_pass
        assign o_q = i_d;
    end else begin : g_pipe
        logic [WIDTH-1:0] r_q [DEPTH];

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_q[i] <= '1;
                end
            end else if (i_en) begin
                r_q[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) begin
                    r_q[i] <= r_q[i-1];
                end
            end
        end

        assign o_q = r_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel strobe, square pixel clock,
// DrawX/DrawY/blank and pipeline-aligned active-low hs/vs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic   Clk,
    input  logic   Reset,
    output logic   pixel_en,
    output logic   vga_clk,
    output coord_t DrawX,
    output coord_t DrawY,
    output logic   blank,
    output logic   hs,
    output logic   vs,
    output logic   sync,
    output logic   line_start,
    output logic   frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t H_SYN_LO = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t H_SYN_HI = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t V_SYN_LO = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t V_SYN_HI = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] r_div;
    coord_t           r_hc;
    coord_t           r_vc;
    logic             r_blank;
    logic             r_hs_raw;
    logic             r_vs_raw;
    logic             r_line_start;
    logic             r_frame_start;

    logic             w_pixel_en;
    logic             w_h_wrap;
    coord_t           w_hc_next;
    coord_t           w_vc_next;
    logic [1:0]       w_sync_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_pixel_en = (r_div == DIV_LAST);
    assign w_h_wrap   = (r_hc == H_LAST);
    assign w_hc_next  = w_h_wrap ? '0 : r_hc + 1'b1;

    always_comb begin
        w_vc_next = r_vc;
        if (w_h_wrap) begin
            w_vc_next = (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
        end
    end

    // Everything keyed to position is decoded from the next-state
    // counters so it lands on the same edge as DrawX/DrawY.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hc          <= H_LAST;
            r_vc          <= V_LAST;
            r_blank       <= 1'b0;
            r_hs_raw      <= 1'b1;
            r_vs_raw      <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (w_pixel_en) begin
                r_hc          <= w_hc_next;
                r_vc          <= w_vc_next;
                r_blank       <= (w_hc_next < H_VIS) && (w_vc_next < V_VIS);
                r_hs_raw      <= !in_window(w_hc_next, H_SYN_LO, H_SYN_HI);
                r_vs_raw      <= !in_window(w_vc_next, V_SYN_LO, V_SYN_HI);
                r_line_start  <= (w_hc_next == '0);
                r_frame_start <= (w_hc_next == '0) && (w_vc_next == '0);
            end
        end
    end

    vga_sync_delay #(
        .WIDTH (2),
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .Clk   (Clk),
        .Reset (Reset),
        .i_en  (w_pixel_en),
        .i_d   ({r_hs_raw, r_vs_raw}),
        .o_q   (w_sync_q)
    );

    assign pixel_en    = w_pixel_en;
    assign vga_clk     = (r_div >= DIV_HALF);
    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign blank       = r_blank;
    assign hs          = w_sync_q[1];
    assign vs          = w_sync_q[0];
    assign sync        = 1'b0;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: one default-timing DUT and one shrunken-raster DUT
// checked each Clk against an arithmetic model of the raster.
module tb_vga_timing_gen;

    localparam int HV[2] = '{640, 16};
    localparam int HF[2] = '{16, 4};
    localparam int HS[2] = '{96, 6};
    localparam int HB[2] = '{48, 4};
    localparam int VV[2] = '{480, 10};
    localparam int VF[2] = '{10, 2};
    localparam int VS[2] = '{2, 2};
    localparam int VB[2] = '{33, 3};
    localparam int CD[2] = '{2, 4};
    localparam int PD[2] = '{2, 3};

    typedef struct {
        int x;
        int y;
        bit blank;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
        bit pe;
        bit vclk;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b0;

    logic       pe   [2];
    logic       vclk [2];
    logic [9:0] dx   [2];
    logic [9:0] dy   [2];
    logic       blk  [2];
    logic       hs   [2];
    logic       vs   [2];
    logic       syn  [2];
    logic       ls   [2];
    logic       fs   [2];

    int   n_chk  = 0;
    int   n_pass = 0;
    int   e      = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    always #5 Clk = ~Clk;

    vga_timing_gen u_def (
        .Clk(Clk), .Reset(Reset), .pixel_en(pe[0]), .vga_clk(vclk[0]),
        .DrawX(dx[0]), .DrawY(dy[0]), .blank(blk[0]), .hs(hs[0]),
        .vs(vs[0]), .sync(syn[0]), .line_start(ls[0]),
        .frame_start(fs[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV(4), .PIPE_DELAY(3)
    ) u_sm (
        .Clk(Clk), .Reset(Reset), .pixel_en(pe[1]), .vga_clk(vclk[1]),
        .DrawX(dx[1]), .DrawY(dy[1]), .blank(blk[1]), .hs(hs[1]),
        .vs(vs[1]), .sync(syn[1]), .line_start(ls[1]),
        .frame_start(fs[1])
    );

    // e = Clk edges since reset released; tick index follows from it.
    function automatic exp_t model(input int d, input int ev);
        exp_t r;
        int ht, vt, p, q, qx, qy;
        ht = HV[d] + HF[d] + HS[d] + HB[d];
        vt = VV[d] + VF[d] + VS[d] + VB[d];
        p  = ev / CD[d] - 1;
        r.pe   = (ev % CD[d]) == CD[d] - 1;
        r.vclk = (ev % CD[d]) >= CD[d] / 2;
        if (p < 0) begin
            r.x = ht - 1;
            r.y = vt - 1;
        end else begin
            r.x = p % ht;
            r.y = (p / ht) % vt;
        end
        r.blank = (p >= 0) && (r.x < HV[d]) && (r.y < VV[d]);
        q = p - PD[d];
        r.hs = 1'b1;
        r.vs = 1'b1;
        if (q >= 0) begin
            qx = q % ht;
            qy = (q / ht) % vt;
            r.hs = !(qx >= HV[d] + HF[d] && qx < HV[d] + HF[d] + HS[d]);
            r.vs = !(qy >= VV[d] + VF[d] && qy < VV[d] + VF[d] + VS[d]);
        end
        r.ls = (ev > 0) && (ev % CD[d] == 0) && (r.x == 0);
        r.fs = r.ls && (r.y == 0);
        return r;
    endfunction

    task automatic chk(input int d, input string nm,
                       input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL dut%0d %s got %0d want %0d at %0t",
                     d, nm, got, want, $time);
        end
    endtask

    initial begin : model_edges
        forever begin
            @(posedge Clk);
            if (!Reset) e++;
        end
    end

    initial begin : model_push
        forever begin
            @(negedge Clk);
            if (Reset) e = 0;
            sb0.push_back(model(0, e));
            sb1.push_back(model(1, e));
        end
    end

    initial begin : monitor
        exp_t x;
        int   pe_cnt[2], blk_cnt[2], cyc_cnt[2];
        bit   seen_ls[2], seen_fs[2];
        int   ht, vt;
        pe_cnt  = '{0, 0};
        blk_cnt = '{0, 0};
        cyc_cnt = '{0, 0};
        seen_ls = '{0, 0};
        seen_fs = '{0, 0};
        forever begin
            @(negedge Clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if ((d == 0 ? sb0.size() : sb1.size()) == 0) begin
                    chk(d, "scoreboard_empty", 1, 0);
                    continue;
                end
                x = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                chk(d, "DrawX", 32'(dx[d]), x.x);
                chk(d, "DrawY", 32'(dy[d]), x.y);
                chk(d, "blank", 32'(blk[d]), 32'(x.blank));
                chk(d, "hs", 32'(hs[d]), 32'(x.hs));
                chk(d, "vs", 32'(vs[d]), 32'(x.vs));
                chk(d, "line_start", 32'(ls[d]), 32'(x.ls));
                chk(d, "frame_start", 32'(fs[d]), 32'(x.fs));
                chk(d, "pixel_en", 32'(pe[d]), 32'(x.pe));
                chk(d, "vga_clk", 32'(vclk[d]), 32'(x.vclk));
                chk(d, "sync", 32'(syn[d]), 0);

                ht = HV[d] + HF[d] + HS[d] + HB[d];
                vt = VV[d] + VF[d] + VS[d] + VB[d];
                if (Reset) begin
                    seen_ls[d] = 1'b0;
                    seen_fs[d] = 1'b0;
                end
                cyc_cnt[d]++;
                if (pe[d] === 1'b1 && blk[d] === 1'b1) blk_cnt[d]++;
                if (ls[d] === 1'b1) begin
                    if (seen_ls[d]) chk(d, "ticks_per_line", pe_cnt[d], ht);
                    pe_cnt[d]  = 0;
                    seen_ls[d] = 1'b1;
                end else if (pe[d] === 1'b1) begin
                    pe_cnt[d]++;
                end
                if (fs[d] === 1'b1) begin
                    if (seen_fs[d]) begin
                        chk(d, "clks_per_frame", cyc_cnt[d], ht * vt * CD[d]);
                        chk(d, "blank_ticks", blk_cnt[d], HV[d] * VV[d]);
                    end
                    cyc_cnt[d] = 0;
                    blk_cnt[d] = 0;
                    seen_fs[d] = 1'b1;
                end
            end
        end
    end

    initial begin : stimulus
        #1 Reset = 1'b1;
        repeat (5) @(posedge Clk);
        #2 Reset = 1'b0;
        repeat (9000) @(posedge Clk);
        #2 Reset = 1'b1;
        @(posedge Clk);
        #2 Reset = 1'b0;
        repeat ($urandom_range(1500, 3000)) @(posedge Clk);
        #2 Reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge Clk);
        #2 Reset = 1'b0;
        repeat (3000) @(posedge Clk);
        for (int k = 0; k < 4; k++) begin
            #2 Reset = 1'b1;
            repeat ($urandom_range(1, 2)) @(posedge Clk);
            #2 Reset = 1'b0;
            repeat ($urandom_range(200, 2500)) @(posedge Clk);
        end
        repeat (2) @(negedge Clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster timing consumed by every sprite/palette draw block: DrawX/DrawY, blank (1 = visible), plus delayed hs/vs and a square vga_clk for the color-output stage.
- Runs from the 50 MHz system clock and generates a pixel strobe at Clk/CLK_DIV.
- Draw blocks register color one or more vga_clk edges after seeing DrawX/DrawY/blank. hs/vs are therefore delayed by PIPE_DELAY pixel ticks so sync stays aligned with color at the DAC.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, Clk cycles per pixel; must be an even value ≥2
- PIPE_DELAY, 2, extra pixel-tick stages on hs/vs (0..7)

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high
- pixel_en  out  1  one-Clk strobe per pixel tick
- vga_clk  out  1  square pixel clock: low for div<CLK_DIV/2, high otherwise
- DrawX  out  10  current column, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- blank  out  1  1 when DrawX<H_VISIBLE and DrawY<V_VISIBLE
- hs  out  1  hsync, active-low, delayed by PIPE_DELAY ticks
- vs  out  1  vsync, active-low, delayed by PIPE_DELAY ticks
- sync  out  1  composite sync, tied 0
- line_start  out  1  one-Clk pulse when DrawX becomes 0
- frame_start  out  1  one-Clk pulse when (DrawX,DrawY) becomes (0,0)

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Divider:
  - div counts 0..CLK_DIV-1 on every Clk edge and wraps.
  - pixel_en = (div == CLK_DIV-1), decoded from registered div.
  - vga_clk = (div >= CLK_DIV/2), decoded from registered div.
- Counters:
  - hc and vc update only on Clk edges where pixel_en=1.
  - hc increments and wraps H_TOTAL-1→0. On that wrap vc increments; vc wraps V_TOTAL-1→0.
  - DrawX = hc, DrawY = vc, both registered.
- blank: registered on the same edge as the counters, decoded from the next-state counter values, so it always matches DrawX/DrawY.
- Raw sync, registered with the counters:
  - hs_raw = 0 when H_VISIBLE+H_FRONT ≤ next_hc < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs_raw = 0 when next_vc is in 490..491.
- Delay line: hs and vs pass through PIPE_DELAY further registers, each advancing only on pixel_en. PIPE_DELAY=0 drives hs/vs straight from hs_raw/vs_raw.
- line_start / frame_start:
  - Registered; high for exactly the one Clk cycle following the edge on which hc (respectively hc and vc) loaded 0.
  - Low in every other cycle.
- Reset values:
  - div=0, so pixel_en=0 and vga_clk=0.
  - DrawX=H_TOTAL-1 (799), DrawY=V_TOTAL-1 (524), blank=0.
  - hs=1, vs=1, all delay stages=1.
  - line_start=0, frame_start=0, sync=0.
- Start-up sequence after reset deasserts:
  - Edge 1: div becomes 1 and pixel_en is asserted.
  - Edge 2: counters roll to (0,0); blank=1, line_start=1, frame_start=1.
  - Result: pixel (0,0) is never skipped.
- Reset mid-frame: all state returns to reset values immediately; no partial line or frame state survives; the next frame starts cleanly per the start-up sequence.
- Boundaries:
  - Simultaneous hc and vc wrap produces a single edge that sets both line_start and frame_start.
  - blank falls when DrawX moves from 639 to 640 and when DrawY moves from 479 to 480.

Decomposition:
- Package vga_pkg holds:
  - the default timing constants and derived H_TOTAL/V_TOTAL;
  - the coordinate typedef (10-bit).
- Sub-module vga_sync_delay: width-2, depth-PIPE_DELAY shift register with enable and reset-to-1. Instantiated once for {hs,vs}.

Test Plan:
- Reset: hold Reset 5 cycles, release → DrawX=799, DrawY=524, blank=0, hs=vs=1 during reset. First pixel_en 1 cycle after release; (0,0) with frame_start=1 after the 2nd edge.
- Line timing: count pixel_en between line_start pulses → exactly 800. blank=1 for 640 consecutive ticks per visible line. vga_clk period = 2 Clk.
- hsync, PIPE_DELAY=2: hs falls while DrawX=658; stays low 96 ticks; rises while DrawX=754.
- Frame timing: frame_start pulses 840000 Clk cycles apart. vs low for 1600 ticks starting at DrawY=490, DrawX=2. blank-high ticks per frame = 307200.
- Wrap: at DrawX=799, DrawY=524, the next tick gives (0,0) with line_start and frame_start both high for one Clk cycle.
- Mid-frame reset: assert Reset at DrawX=300, DrawY=200 for 1 cycle → outputs immediately return to reset values; next frame_start follows 2 cycles after release.
